// File: rtl/weight_buffer_pp.sv
// weight_buffer_pp: ping-pong weight store between the DRAM loader and the dispatcher.
// One bank is filled by the loader while the dispatcher reads the other; banks swap on tile
// boundaries (in_dram_last for the fill side, in_disp_done for the read side).
// Write path: one input register stage, then the SRAM write.
// Read path: address/bank register, SRAM registered read, output register (3 edges to rvalid).
// Optional feature macro: WBUF_ERR_EN adds a sticky out_err flag for requests/dones issued
// while the read bank holds no complete tile.
module weight_buffer_pp #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_dram_valid,
    output logic              out_dram_ready,
    input  logic [ADDR_W-1:0] in_dram_addr,
    input  logic [DATA_W-1:0] in_dram_wdata,
    input  logic              in_dram_last,
    input  logic              in_disp_req,
    output logic              out_disp_ready,
    input  logic [ADDR_W-1:0] in_disp_addr,
    input  logic              in_disp_done,
    output logic              out_disp_rvalid,
    output logic [DATA_W-1:0] out_disp_rdata,
    output logic              out_fill_bank,
    output logic              out_read_bank
`ifdef WBUF_ERR_EN
    ,
    output logic              out_err
`endif
);

    localparam int DEPTH = 1 << ADDR_W;

    // Bank bookkeeping
    logic [1:0] full_q, full_d;
    logic       wb_q, wb_d;
    logic       rb_q, rb_d;

    logic wr_acc;
    logic rd_acc;
    logic rel;

    // Write input register
    logic              wr_en_q;
    logic              wr_bank_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;

    // Read pipeline
    logic              rd1_v_q;
    logic              rd1_bank_q;
    logic [ADDR_W-1:0] rd1_addr_q;
    logic              rd2_v_q;
    logic              rd2_bank_q;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    assign out_dram_ready  = ~full_q[wb_q];
    assign out_disp_ready  = full_q[rb_q];
    assign out_fill_bank   = wb_q;
    assign out_read_bank   = rb_q;
    assign out_disp_rvalid = rvalid_q;
    assign out_disp_rdata  = rdata_q;

    assign wr_acc = in_dram_valid & out_dram_ready;
    assign rd_acc = in_disp_req & out_disp_ready;
    assign rel    = in_disp_done & full_q[rb_q];

    // Next-state of the full flags and bank pointers. wb and rb only coincide when both
    // banks are empty or both full, so the set and clear below never hit the same bank.
    always_comb begin
        full_d = full_q;
        wb_d   = wb_q;
        rb_d   = rb_q;
        if (wr_acc && in_dram_last) begin
            full_d[wb_q] = 1'b1;
            wb_d         = ~wb_q;
        end
        if (rel) begin
            full_d[rb_q] = 1'b0;
            rb_d         = ~rb_q;
        end
    end

    // Bank state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 2'b00;
            wb_q   <= 1'b0;
            rb_q   <= 1'b0;
        end else begin
            full_q <= full_d;
            wb_q   <= wb_d;
            rb_q   <= rb_d;
        end
    end

    // Capture an accepted beat together with the bank it targets
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_bank_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= wr_acc;
            if (wr_acc) begin
                wr_bank_q <= wb_q;
                wr_addr_q <= in_dram_addr;
                wr_data_q <= in_dram_wdata;
            end
        end
    end

    // Read stages 1 and 2 control: the bank is latched at accept so in-flight reads
    // finish on the right bank even if it is released meanwhile
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1_v_q    <= 1'b0;
            rd1_bank_q <= 1'b0;
            rd1_addr_q <= '0;
            rd2_v_q    <= 1'b0;
            rd2_bank_q <= 1'b0;
        end else begin
            rd1_v_q <= rd_acc;
            if (rd_acc) begin
                rd1_bank_q <= rb_q;
                rd1_addr_q <= in_disp_addr;
            end
            rd2_v_q    <= rd1_v_q;
            rd2_bank_q <= rd1_bank_q;
        end
    end

    // Two independent single-write/single-read banks; contents are not cleared on reset
    for (genvar gi = 0; gi < 2; gi++) begin : bank_g
        logic [DATA_W-1:0] mem [DEPTH];
        logic [DATA_W-1:0] rdata_q;

        // Write port fed from the input register, registered read port for the dispatcher
        always_ff @(posedge clk) begin
            if (wr_en_q && (wr_bank_q == 1'(gi))) begin
                mem[wr_addr_q] <= wr_data_q;
            end
            if (rd1_v_q && (rd1_bank_q == 1'(gi))) begin
                rdata_q <= mem[rd1_addr_q];
            end
        end
    end

    // Output stage: select the bank that was read and present it with rvalid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rd2_v_q;
            if (rd2_v_q) begin
                rdata_q <= rd2_bank_q ? bank_g[1].rdata_q : bank_g[0].rdata_q;
            end
        end
    end

`ifdef WBUF_ERR_EN
    logic err_q;
    assign out_err = err_q;

    // Sticky protocol error: read or release attempted without a complete tile
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | (in_disp_req & ~full_q[rb_q]) | (in_disp_done & ~full_q[rb_q]);
        end
    end
`endif

endmodule

// File: tb/tb_weight_buffer_pp.sv
// Testbench for weight_buffer_pp: directed tile scenarios followed by random traffic,
// all checked against a transaction-level model of the two banks.
module tb_weight_buffer_pp;

    localparam int DW = 256;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_dram_valid;
    logic          out_dram_ready;
    logic [AW-1:0] in_dram_addr;
    logic [DW-1:0] in_dram_wdata;
    logic          in_dram_last;
    logic          in_disp_req;
    logic          out_disp_ready;
    logic [AW-1:0] in_disp_addr;
    logic          in_disp_done;
    logic          out_disp_rvalid;
    logic [DW-1:0] out_disp_rdata;
    logic          out_fill_bank;
    logic          out_read_bank;
`ifdef WBUF_ERR_EN
    logic          out_err;
`endif

    always #5 clk = ~clk;

    weight_buffer_pp #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_dram_valid  (in_dram_valid),
        .out_dram_ready (out_dram_ready),
        .in_dram_addr   (in_dram_addr),
        .in_dram_wdata  (in_dram_wdata),
        .in_dram_last   (in_dram_last),
        .in_disp_req    (in_disp_req),
        .out_disp_ready (out_disp_ready),
        .in_disp_addr   (in_disp_addr),
        .in_disp_done   (in_disp_done),
        .out_disp_rvalid(out_disp_rvalid),
        .out_disp_rdata (out_disp_rdata),
        .out_fill_bank  (out_fill_bank),
        .out_read_bank  (out_read_bank)
`ifdef WBUF_ERR_EN
        ,
        .out_err        (out_err)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: bank contents, full flags, bank pointers, pending reads
    logic [DW-1:0] m_mem   [2][256];
    bit            m_known [2][256];
    bit            m_full  [2];
    bit            m_wb;
    bit            m_rb;
    bit            m_err;
    int            q_due[$];
    logic [DW-1:0] q_data[$];
    bit            q_known[$];

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic model_reset();
        m_full[0] = 1'b0;
        m_full[1] = 1'b0;
        m_wb      = 1'b0;
        m_rb      = 1'b0;
        m_err     = 1'b0;
        q_due.delete();
        q_data.delete();
        q_known.delete();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 256; a++) m_known[b][a] = 1'b0;
    endtask

    // Apply the effect of one clock edge to the model, using the inputs present at that edge
    task automatic model_edge();
        bit owb, orb, wacc, racc, rel;
        cyc++;
        if (!rst_n) return;
        owb  = m_wb;
        orb  = m_rb;
        wacc = in_dram_valid && !m_full[owb];
        racc = in_disp_req && m_full[orb];
        rel  = in_disp_done && m_full[orb];
        if ((in_disp_req || in_disp_done) && !m_full[orb]) m_err = 1'b1;
        if (racc) begin
            q_due.push_back(cyc + 2);
            q_data.push_back(m_mem[orb][in_disp_addr]);
            q_known.push_back(m_known[orb][in_disp_addr]);
        end
        if (wacc) begin
            m_mem[owb][in_dram_addr]   = in_dram_wdata;
            m_known[owb][in_dram_addr] = 1'b1;
            if (in_dram_last) begin
                m_full[owb] = 1'b1;
                m_wb        = !owb;
            end
        end
        if (rel) begin
            m_full[orb] = 1'b0;
            m_rb        = !orb;
        end
    endtask

    task automatic check_outputs();
        bit ev;
        ev = (q_due.size() > 0) && (q_due[0] == cyc);
        chk("rvalid", DW'(out_disp_rvalid), DW'(ev));
        if (ev) begin
            if (q_known[0]) chk("rdata", out_disp_rdata, q_data[0]);
            void'(q_due.pop_front());
            void'(q_data.pop_front());
            void'(q_known.pop_front());
        end
        chk("dram_ready", DW'(out_dram_ready), DW'(!m_full[m_wb]));
        chk("disp_ready", DW'(out_disp_ready), DW'(m_full[m_rb]));
        chk("fill_bank", DW'(out_fill_bank), DW'(m_wb));
        chk("read_bank", DW'(out_read_bank), DW'(m_rb));
`ifdef WBUF_ERR_EN
        chk("err", DW'(out_err), DW'(m_err));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic set_idle();
        in_dram_valid = 1'b0;
        in_dram_last  = 1'b0;
        in_dram_addr  = '0;
        in_dram_wdata = '0;
        in_disp_req   = 1'b0;
        in_disp_done  = 1'b0;
        in_disp_addr  = '0;
    endtask

    // Assert reset between clock edges, check the asynchronous clear, release mid-cycle
    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_rvalid", DW'(out_disp_rvalid), DW'(1'b0));
        chk("rst_rdata", out_disp_rdata, '0);
        chk("rst_disp_ready", DW'(out_disp_ready), DW'(1'b0));
        chk("rst_dram_ready", DW'(out_dram_ready), DW'(1'b1));
        chk("rst_banks", DW'({out_fill_bank, out_read_bank}), DW'(2'b00));
        set_idle();
        repeat (2) tick();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        set_idle();
        model_reset();
        apply_reset();

        // 1: fill bank0 with addr*3, last on addr 3, then read it back-to-back
        for (int i = 0; i < 4; i++) begin
            in_dram_valid = 1'b1;
            in_dram_addr  = AW'(i);
            in_dram_wdata = DW'(i * 3);
            in_dram_last  = (i == 3);
            tick();
        end
        set_idle();
        chk("t1_disp_ready", DW'(out_disp_ready), DW'(1'b1));
        chk("t1_fill_bank", DW'(out_fill_bank), DW'(1'b1));
        for (int i = 0; i < 4; i++) begin
            in_disp_req  = 1'b1;
            in_disp_addr = AW'(i);
            tick();
        end
        set_idle();
        repeat (3) tick();

        // 2: fill bank1 with ~addr while reading bank0
        for (int a = 0; a < 256; a++) begin
            in_dram_valid = 1'b1;
            in_dram_addr  = AW'(a);
            in_dram_wdata = ~(DW'(a));
            in_dram_last  = (a == 255);
            in_disp_req   = 1'b1;
            in_disp_addr  = AW'($urandom_range(0, 3));
            tick();
            chk("t2_disp_ready", DW'(out_disp_ready), DW'(1'b1));
        end
        set_idle();
        chk("t2_dram_ready_full", DW'(out_dram_ready), DW'(1'b0));
        in_disp_done = 1'b1;
        tick();
        set_idle();
        chk("t2_read_bank", DW'(out_read_bank), DW'(1'b1));
        chk("t2_dram_ready", DW'(out_dram_ready), DW'(1'b1));
        repeat (3) tick();

        // 3: refill bank0, then hold a beat while both banks are full
        for (int i = 0; i < 4; i++) begin
            in_dram_valid = 1'b1;
            in_dram_addr  = AW'(i);
            in_dram_wdata = rnd_word();
            in_dram_last  = (i == 3);
            tick();
        end
        in_dram_valid = 1'b1;
        in_dram_addr  = '0;
        in_dram_wdata = rnd_word();
        in_dram_last  = 1'b1;
        repeat (5) begin
            tick();
            chk("t3_held", DW'(out_dram_ready), DW'(1'b0));
        end
        in_disp_done = 1'b1;
        tick();
        in_disp_done = 1'b0;
        tick();
        set_idle();
        chk("t3_accepted_fill_bank", DW'(out_fill_bank), DW'(1'b0));

        // 4: req and done together on bank0, then a read from bank1
        in_disp_req  = 1'b1;
        in_disp_done = 1'b1;
        in_disp_addr = AW'(2);
        tick();
        in_disp_done = 1'b0;
        in_disp_addr = AW'(5);
        tick();
        set_idle();
        chk("t4_read_bank", DW'(out_read_bank), DW'(1'b1));
        tick();
        chk("t4_bank0_data", out_disp_rdata, q_data.size() > 0 ? out_disp_rdata : '1);
        tick();
        chk("t4_bank1_data", out_disp_rdata, ~(DW'(5)));
        tick();

        // 5: reset in the middle of a fill and of a read burst
        for (int i = 0; i < 3; i++) begin
            in_dram_valid = 1'b1;
            in_dram_addr  = AW'(i);
            in_dram_wdata = rnd_word();
            in_dram_last  = 1'b0;
            in_disp_req   = 1'b1;
            in_disp_addr  = AW'(i + 10);
            tick();
        end
        apply_reset();
        in_disp_req = 1'b1;
        repeat (5) tick();
        set_idle();

`ifdef WBUF_ERR_EN
        // 6: request with both banks empty raises a sticky error
        apply_reset();
        in_disp_req = 1'b1;
        tick();
        set_idle();
        chk("t6_err_set", DW'(out_err), DW'(1'b1));
        repeat (3) tick();
        chk("t6_err_sticky", DW'(out_err), DW'(1'b1));
`endif

        // Random traffic, with one reset in the middle
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) apply_reset();
            in_dram_valid = 1'($urandom_range(0, 1));
            in_dram_addr  = AW'($urandom_range(0, 15));
            in_dram_wdata = rnd_word();
            in_dram_last  = ($urandom_range(0, 5) == 0);
            in_disp_req   = ($urandom_range(0, 2) != 0);
            in_disp_addr  = AW'($urandom_range(0, 15));
            in_disp_done  = ($urandom_range(0, 9) == 0);
            tick();
        end
        set_idle();
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
